// File: rtl/fifo_vc_pkg.sv
// Shared sizing, default thresholds and umbral_VCFC field positions for the
// virtual-channel FIFO.
package fifo_vc_pkg;

   localparam int DATA_W = 10;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int CNT_W  = ADDR_W + 1;
   localparam int THR_W  = 4;

   localparam logic [THR_W-1:0] AF_DEFAULT = 4'd6;
   localparam logic [THR_W-1:0] AE_DEFAULT = 4'd1;

   localparam int AF_MSB = 7;
   localparam int AF_LSB = 4;
   localparam int AE_MSB = 3;
   localparam int AE_LSB = 0;

   localparam logic [THR_W-1:0] DEPTH_THR = THR_W'(DEPTH);

   // An almost-full threshold above DEPTH could never trigger, so it saturates.
   function automatic logic [THR_W-1:0] clamp_af(input logic [THR_W-1:0] thr);
      return (thr > DEPTH_THR) ? DEPTH_THR : thr;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register file: one synchronous write port, one registered
// read port, no reset on either the array or the read register.
module fifo_mem
   import fifo_vc_pkg::*;
(
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data_d;
   logic [DATA_W-1:0] rd_data_q;

   // A simultaneous write to the read address returns the old word.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) rd_data_d = mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_vc.sv
// Virtual-channel FIFO: pointers, occupancy, programmable flow-control
// thresholds, status flags and the sticky error flag feeding the control FSM.
module fifo_vc
   import fifo_vc_pkg::*;
(
   input  logic              clk,
   input  logic              reset_L,
   input  logic              init,
   input  logic [7:0]        umbral_VCFC,
   input  logic              push,
   input  logic [DATA_W-1:0] data_in,
   input  logic              pop,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              FIFO_empty,
   output logic              FIFO_full,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              FIFO_error
);

   logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q;
   logic [ADDR_W-1:0] rd_ptr_d, rd_ptr_q;
   logic [CNT_W-1:0]  count_d, count_q;
   logic [THR_W-1:0]  af_thr_d, af_thr_q;
   logic [THR_W-1:0]  ae_thr_d, ae_thr_q;
   logic              valid_d, valid_q;
   logic              error_d, error_q;
   logic              rd_seen_d, rd_seen_q;
   logic              push_ok, pop_ok;
   logic [DATA_W-1:0] mem_rd_data;

   always_comb begin
      push_ok   = push & (~FIFO_full | pop);
      pop_ok    = pop & ~FIFO_empty;
      wr_ptr_d  = push_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
      rd_ptr_d  = pop_ok ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
      count_d   = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      valid_d   = pop_ok;
      rd_seen_d = rd_seen_q | pop_ok;
      error_d   = error_q | (push & FIFO_full & ~pop) | (pop & FIFO_empty);
      af_thr_d  = af_thr_q;
      ae_thr_d  = ae_thr_q;
      if (init) begin
         af_thr_d = clamp_af(umbral_VCFC[AF_MSB:AF_LSB]);
         ae_thr_d = umbral_VCFC[AE_MSB:AE_LSB];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         af_thr_q  <= AF_DEFAULT;
         ae_thr_q  <= AE_DEFAULT;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
         rd_seen_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         af_thr_q  <= af_thr_d;
         ae_thr_q  <= ae_thr_d;
         valid_q   <= valid_d;
         error_q   <= error_d;
         rd_seen_q <= rd_seen_d;
      end
   end

   fifo_mem u_mem (
      .clk     (clk),
      .wr_en   (push_ok),
      .wr_addr (wr_ptr_q),
      .wr_data (data_in),
      .rd_en   (pop_ok),
      .rd_addr (rd_ptr_q),
      .rd_data (mem_rd_data)
   );

   // The read register has no reset, so data_out reads zero until the first pop.
   assign data_out     = rd_seen_q ? mem_rd_data : '0;
   assign data_valid   = valid_q;
   assign FIFO_error   = error_q;
   assign FIFO_empty   = (count_q == '0);
   assign FIFO_full    = (count_q == CNT_W'(DEPTH));
   assign almost_full  = (32'(count_q) >= 32'(af_thr_q));
   assign almost_empty = (32'(count_q) <= 32'(ae_thr_q));

endmodule

// File: tb/tb_fifo_vc.sv
// Self-checking bench for fifo_vc: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_fifo_vc;

   logic       clk = 1'b0;
   logic       reset_L;
   logic       init;
   logic [7:0] umbral_VCFC;
   logic       push;
   logic [9:0] data_in;
   logic       pop;
   logic [9:0] data_out;
   logic       data_valid;
   logic       FIFO_empty;
   logic       FIFO_full;
   logic       almost_full;
   logic       almost_empty;
   logic       FIFO_error;

   int num_checks = 0;
   int num_fails  = 0;

   logic [9:0] model_q[$];
   int         model_af;
   int         model_ae;
   logic [9:0] model_dout;
   logic       model_valid;
   logic       model_err;

   fifo_vc dut (
      .clk          (clk),
      .reset_L      (reset_L),
      .init         (init),
      .umbral_VCFC  (umbral_VCFC),
      .push         (push),
      .data_in      (data_in),
      .pop          (pop),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .FIFO_empty   (FIFO_empty),
      .FIFO_full    (FIFO_full),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .FIFO_error   (FIFO_error)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      num_checks++;
      if (observed !== expected) begin
         num_fails++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
      end
   endtask

   // Reference behaviour applied at a clock edge, using the pre-edge state.
   task automatic model_step(input logic rst, input logic ini, input logic [7:0] thr,
                             input logic psh, input logic pp, input logic [9:0] din);
      int  sz;
      bit  full, empty, push_ok, pop_ok;
      if (rst) begin
         model_q.delete();
         model_dout  = '0;
         model_valid = 1'b0;
         model_err   = 1'b0;
         model_af    = 6;
         model_ae    = 1;
         return;
      end
      sz      = model_q.size();
      full    = (sz == 8);
      empty   = (sz == 0);
      push_ok = psh && (!full || pp);
      pop_ok  = pp && !empty;
      if (pop_ok) model_dout = model_q.pop_front();
      model_valid = pop_ok;
      if (push_ok) model_q.push_back(din);
      if ((psh && full && !pp) || (pp && empty)) model_err = 1'b1;
      if (ini) begin
         model_af = (int'(thr[7:4]) > 8) ? 8 : int'(thr[7:4]);
         model_ae = int'(thr[3:0]);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic ini, input logic [7:0] thr,
                                input logic psh, input logic pp, input logic [9:0] din);
      int sz;
      reset_L     = ~rst;
      init        = ini;
      umbral_VCFC = thr;
      push        = psh;
      pop         = pp;
      data_in     = din;
      @(posedge clk);
      model_step(rst, ini, thr, psh, pp, din);
      #1;
      sz = model_q.size();
      checkOutput("data_valid", 32'(data_valid), 32'(model_valid));
      checkOutput("data_out", 32'(data_out), 32'(model_dout));
      checkOutput("FIFO_empty", 32'(FIFO_empty), 32'(sz == 0));
      checkOutput("FIFO_full", 32'(FIFO_full), 32'(sz == 8));
      checkOutput("almost_full", 32'(almost_full), 32'(sz >= model_af));
      checkOutput("almost_empty", 32'(almost_empty), 32'(sz <= model_ae));
      checkOutput("FIFO_error", 32'(FIFO_error), 32'(model_err));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 10'h000);
   endtask

   initial begin
      model_af = 6;
      model_ae = 1;
      model_dout = '0;
      model_valid = 1'b0;
      model_err = 1'b0;

      // Reset and idle
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 10'h000);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 10'h000);
      idle(2);

      // Fill with 1..8, drain in order
      for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 10'(i));
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 10'h000);
      idle(1);

      // Thresholds 0xAF: almost_full clamps to 8, almost_empty covers every count
      applyStimulus(1'b0, 1'b1, 8'hAF, 1'b0, 1'b0, 10'h000);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 10'(16 + i));
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 10'h000);

      // Overflow leaves contents intact; error sticks until reset
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 10'(32 + i));
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 10'h3FF);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 10'h000);
      applyStimulus(1'b0, 1'b1, 8'h61, 1'b1, 1'b0, 10'h0AA);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 10'h000);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 10'h000);

      // Push+pop on empty: underflow, push accepted
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 10'h155);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 10'h000);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 10'h000);

      // Push+pop on full with pointer wrap, then reset mid-drain
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 10'(10'h100 + i));
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 10'(10'h200 + i));
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 10'h000);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 10'h000);
      idle(1);

      // Random traffic with occasional threshold reprogramming and reset
      for (int i = 0; i < 1500; i++) begin
         logic r_rst, r_ini, r_psh, r_pp;
         r_rst = ($urandom_range(0, 199) == 0);
         r_ini = ($urandom_range(0, 39) == 0);
         r_psh = ($urandom_range(0, 99) < 55);
         r_pp  = ($urandom_range(0, 99) < 45);
         applyStimulus(r_rst, r_ini, 8'($urandom), r_psh, r_pp, 10'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end

endmodule
